agc_wrout_buffer: RTL

//   Write-out buffer between the AGC datapath and the audio transmit serializer.

---
 rtl/agc_wrout_buffer.sv | 101 ++++++++++
 1 files changed

// File: rtl/agc_wrout_buffer.sv
// First-word-fall-through sample FIFO between the AGC datapath and the transmit serializer.
// Drops samples on overflow and exposes a registered status word for CPU polling.
module agc_wrout_buffer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [DEPTH_LOG2:0]      level,
    output logic [1:0]               status
);

    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam int                  LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]    LEVEL_FULL = LVL_W'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]    wr_ptr;
    logic [DEPTH_LOG2-1:0]    rd_ptr;
    logic                     ovf_sticky;

    logic                     full;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic [LVL_W-1:0]         level_next;
    logic                     ovf_sticky_next;
    logic [CNT_W-1:0]         drop_cnt_next;

    assign full      = (level == LEVEL_FULL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // A drop in the same cycle as a clear wins: the event is never lost.
    always_comb begin
        ovf_sticky_next = ovf_sticky;
        drop_cnt_next   = drop_cnt;
        if (drop) begin
            ovf_sticky_next = 1'b1;
            drop_cnt_next   = ovf_clr ? CNT_W'(1) : sat_inc(drop_cnt);
        end else if (ovf_clr) begin
            ovf_sticky_next = 1'b0;
            drop_cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
            status     <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            level      <= level_next;
            ovf_sticky <= ovf_sticky_next;
            drop_cnt   <= drop_cnt_next;
            // Built from next-state values so status changes on the same edge as level.
            status     <= {ovf_sticky_next, level_next != '0};
        end
    end

endmodule
